// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, state encoding and bit-reverse helper for the FFT read side
package fft_pkg;

    localparam int N_POINTS = 16;
    localparam int IDX_W    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic logic [IDX_W-1:0] bitrev4(input logic [IDX_W-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// rtl/fft_out_serializer_if.sv - frame capture and sample stream signals of the FFT output serializer
interface fft_out_serializer_if #(
    parameter int WORD_SIZE = 16
) ();
    logic                                  load;
    logic [fft_pkg::N_POINTS*WORD_SIZE-1:0] in_re;
    logic [fft_pkg::N_POINTS*WORD_SIZE-1:0] in_im;
    logic                                  load_ready;
    logic                                  load_dropped;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [WORD_SIZE-1:0]                  out_re;
    logic [WORD_SIZE-1:0]                  out_im;
    logic [fft_pkg::IDX_W-1:0]             out_idx;
    logic                                  out_last;

    modport slave (
        input  load, in_re, in_im, out_ready,
        output load_ready, load_dropped, out_valid, out_re, out_im, out_idx, out_last
    );

    modport master (
        output load, in_re, in_im, out_ready,
        input  load_ready, load_dropped, out_valid, out_re, out_im, out_idx, out_last
    );
endinterface

// File: rtl/fft_frame_buf.sv
// rtl/fft_frame_buf.sv - 16-entry complex capture register with a single combinational read port
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we_i,
    input  logic [N_POINTS*WORD_SIZE-1:0] in_re_i,
    input  logic [N_POINTS*WORD_SIZE-1:0] in_im_i,
    input  logic [IDX_W-1:0]              rd_addr_i,
    output logic [WORD_SIZE-1:0]          rd_re_o,
    output logic [WORD_SIZE-1:0]          rd_im_o
);

    logic [WORD_SIZE-1:0] re_q [N_POINTS];
    logic [WORD_SIZE-1:0] im_q [N_POINTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_POINTS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else if (we_i) begin
            for (int k = 0; k < N_POINTS; k++) begin
                re_q[k] <= in_re_i[k*WORD_SIZE +: WORD_SIZE];
                im_q[k] <= in_im_i[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign rd_re_o = re_q[rd_addr_i];
    assign rd_im_o = im_q[rd_addr_i];

endmodule

// File: rtl/fft_out_serializer.sv
// rtl/fft_out_serializer.sv - captures a 16-point complex frame and streams it one sample per beat
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int BIT_REVERSE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_out_serializer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  p_q, p_d;
    logic              dropped_q, dropped_d;
    logic              capture;
    logic              send;
    logic              last_pos;
    logic              load_ready;
    logic [IDX_W-1:0]  rd_addr;

    assign send     = (state_q == ST_SEND);
    assign last_pos = (p_q == IDX_W'(N_POINTS - 1));

    // The final beat's handshake frees the buffer in the same cycle, enabling gapless frames.
    assign load_ready = !send || (bus.out_ready && last_pos);
    assign rd_addr    = (BIT_REVERSE != 0) ? bitrev4(p_q) : p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        capture   = 1'b0;
        dropped_d = dropped_q | (bus.load & ~load_ready);
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    capture = 1'b1;
                    p_d     = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bus.out_ready) begin
                    // Position 15 wraps to 0, ready for either a chained frame or IDLE.
                    p_d = p_q + IDX_W'(1);
                    if (last_pos) begin
                        if (bus.load) begin
                            capture = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fft_frame_buf #(
        .WORD_SIZE (WORD_SIZE)
    ) u_frame_buf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (capture),
        .in_re_i   (bus.in_re),
        .in_im_i   (bus.in_im),
        .rd_addr_i (rd_addr),
        .rd_re_o   (bus.out_re),
        .rd_im_o   (bus.out_im)
    );

    assign bus.load_ready   = load_ready;
    assign bus.load_dropped = dropped_q;
    assign bus.out_valid    = send;
    assign bus.out_idx      = p_q;
    assign bus.out_last     = send & last_pos;

endmodule

// File: tb/tb_fft_out_serializer.sv
// tb/tb_fft_out_serializer.sv - randomized scoreboard bench for linear and bit-reversed serializers
module tb_fft_out_serializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] in_re = '0;
    logic [255:0] in_im = '0;

    always #5 clk = ~clk;

    fft_out_serializer_if #(.WORD_SIZE(16)) if_lin ();
    fft_out_serializer_if #(.WORD_SIZE(16)) if_rev ();

    assign if_lin.load = load;
    assign if_lin.in_re = in_re;
    assign if_lin.in_im = in_im;
    assign if_lin.out_ready = out_ready;
    assign if_rev.load = load;
    assign if_rev.in_re = in_re;
    assign if_rev.in_im = in_im;
    assign if_rev.out_ready = out_ready;

    fft_out_serializer #(.WORD_SIZE(16), .BIT_REVERSE(0)) dut_lin (.clk(clk), .rst(rst), .bus(if_lin.slave));
    fft_out_serializer #(.WORD_SIZE(16), .BIT_REVERSE(1)) dut_rev (.clk(clk), .rst(rst), .bus(if_rev.slave));

    // Reference: each accepted frame becomes 16 queued expected samples per instance.
    logic [15:0] q_re0[$], q_im0[$], q_re1[$], q_im1[$];
    logic        m_drop = 1'b0;
    logic [15:0] fr_re[16], fr_im[16];
    int          checks = 0;
    int          errors = 0;

    function automatic int rev4(input int p);
        return ((p % 2) * 8) + (((p / 2) % 2) * 4) + (((p / 4) % 2) * 2) + ((p / 8) % 2);
    endfunction

    task automatic drive_frame();
        for (int k = 0; k < 16; k++) begin
            in_re[k*16 +: 16] = fr_re[k];
            in_im[k*16 +: 16] = fr_im[k];
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = 16'($urandom);
            fr_im[k] = 16'($urandom);
        end
        drive_frame();
    endtask

    task automatic cycle();
        int          sz;
        logic        ev, elr;
        logic [2:0]  ec;
        logic [36:0] ed0, ed1;
        @(negedge clk);
        sz  = q_re0.size();
        ev  = (sz > 0);
        elr = (sz == 0) || (sz == 1 && out_ready);
        ec  = {ev, elr, m_drop};
        checks += 2;
        if ({if_lin.out_valid, if_lin.load_ready, if_lin.load_dropped} !== ec) begin
            errors++;
            $display("FAIL ctl_lin got %b expected %b at %0t", {if_lin.out_valid, if_lin.load_ready, if_lin.load_dropped}, ec, $time);
        end
        if ({if_rev.out_valid, if_rev.load_ready, if_rev.load_dropped} !== ec) begin
            errors++;
            $display("FAIL ctl_rev got %b expected %b at %0t", {if_rev.out_valid, if_rev.load_ready, if_rev.load_dropped}, ec, $time);
        end
        checks += 2;
        if (ev) begin
            ed0 = {4'(16 - sz), (sz == 1), q_re0[0], q_im0[0]};
            ed1 = {4'(16 - sz), (sz == 1), q_re1[0], q_im1[0]};
            if ({if_lin.out_idx, if_lin.out_last, if_lin.out_re, if_lin.out_im} !== ed0) begin
                errors++;
                $display("FAIL data_lin got %h expected %h at %0t", {if_lin.out_idx, if_lin.out_last, if_lin.out_re, if_lin.out_im}, ed0, $time);
            end
            if ({if_rev.out_idx, if_rev.out_last, if_rev.out_re, if_rev.out_im} !== ed1) begin
                errors++;
                $display("FAIL data_rev got %h expected %h at %0t", {if_rev.out_idx, if_rev.out_last, if_rev.out_re, if_rev.out_im}, ed1, $time);
            end
        end else begin
            if (if_lin.out_last !== 1'b0) begin
                errors++;
                $display("FAIL last_idle_lin got %b expected 0 at %0t", if_lin.out_last, $time);
            end
            if (if_rev.out_last !== 1'b0) begin
                errors++;
                $display("FAIL last_idle_rev got %b expected 0 at %0t", if_rev.out_last, $time);
            end
        end
        @(posedge clk);
        if (rst) begin
            q_re0.delete(); q_im0.delete(); q_re1.delete(); q_im1.delete();
            m_drop = 1'b0;
        end else begin
            if (ev && out_ready) begin
                void'(q_re0.pop_front()); void'(q_im0.pop_front());
                void'(q_re1.pop_front()); void'(q_im1.pop_front());
            end
            if (load && elr) begin
                for (int p = 0; p < 16; p++) begin
                    q_re0.push_back(fr_re[p]);
                    q_im0.push_back(fr_im[p]);
                    q_re1.push_back(fr_re[rev4(p)]);
                    q_im1.push_back(fr_im[rev4(p)]);
                end
            end else if (load) begin
                m_drop = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        load = 1'b0;
        for (int i = 0; i < 100 && q_re0.size() > 0; i++) cycle();
        cycle();
        checks++;
        if (q_re0.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout remaining %0d expected 0", q_re0.size());
        end
    endtask

    task automatic wait_remaining(input int n);
        for (int i = 0; i < 60 && q_re0.size() != n; i++) cycle();
        checks++;
        if (q_re0.size() != n) begin
            errors++;
            $display("FAIL wait_timeout remaining %0d expected %0d", q_re0.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; out_ready = 1'b1;
        rand_frame();
        cycle();
        cycle();
        rst = 1'b0; load = 1'b0;
        checks++;
        if ({if_lin.out_valid, if_lin.out_last, if_lin.out_re, if_lin.out_im, if_lin.out_idx, if_lin.load_ready, if_lin.load_dropped} !== {1'b0, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs valid=%b last=%b re=%h im=%h idx=%h ready=%b drop=%b", if_lin.out_valid, if_lin.out_last, if_lin.out_re, if_lin.out_im, if_lin.out_idx, if_lin.load_ready, if_lin.load_dropped);
        end
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_linear();
        int lastcnt = 0;
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = 16'(k);
            fr_im[k] = 16'(-k);
        end
        drive_frame();
        out_ready = 1'b1; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (if_lin.out_last === 1'b1) lastcnt++;
            checks++;
            if ({if_lin.out_re, if_lin.out_im, if_lin.out_idx} !== {16'(i), 16'(-i), 4'(i)}) begin
                errors++;
                $display("FAIL linear_beat%0d got re=%h im=%h idx=%0d", i, if_lin.out_re, if_lin.out_im, if_lin.out_idx);
            end
            cycle();
        end
        checks += 2;
        if (lastcnt != 1) begin
            errors++;
            $display("FAIL linear_last_count got %0d expected 1", lastcnt);
        end
        if ({if_lin.out_valid, if_lin.load_ready} !== 2'b01) begin
            errors++;
            $display("FAIL linear_after valid=%b ready=%b expected 0 1", if_lin.out_valid, if_lin.load_ready);
        end
        cycle();
    endtask

    task automatic test_backpressure();
        int hs = 0;
        rand_frame();
        out_ready = 1'b1; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 200 && q_re0.size() > 0; i++) begin
            out_ready = ((i % 3) == 0);
            if (if_lin.out_valid && out_ready) hs++;
            cycle();
        end
        checks++;
        if (hs != 16) begin
            errors++;
            $display("FAIL backpressure_handshakes got %0d expected 16", hs);
        end
        drain();
    endtask

    task automatic test_reorder();
        int tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int n = 0;
        logic [15:0] obs[16];
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = 16'(k);
            fr_im[k] = 16'($urandom);
        end
        drive_frame();
        out_ready = 1'b1; load = 1'b1;
        cycle();
        load = 1'b0;
        for (int i = 0; i < 200 && n < 16; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (if_rev.out_valid && out_ready) begin
                obs[n] = if_rev.out_re;
                n++;
            end
            cycle();
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== 16'(tbl[i])) begin
                errors++;
                $display("FAIL reorder_beat%0d got %0d expected %0d", i, obs[i], tbl[i]);
            end
        end
        drain();
    endtask

    task automatic test_collision();
        rand_frame();
        out_ready = 1'b1; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_remaining(11);
        rand_frame();
        load = 1'b1;
        cycle();
        load = 1'b0;
        checks++;
        if (if_lin.load_dropped !== 1'b1) begin
            errors++;
            $display("FAIL dropped_flag got %b expected 1", if_lin.load_dropped);
        end
        wait_remaining(1);
        rand_frame();
        load = 1'b1;
        cycle();
        load = 1'b0;
        checks++;
        if ({if_lin.out_valid, if_lin.out_idx, if_lin.out_re, if_rev.out_re} !== {1'b1, 4'h0, fr_re[0], fr_re[0]}) begin
            errors++;
            $display("FAIL back_to_back valid=%b idx=%0d re=%h rev_re=%h expected 1 0 %h", if_lin.out_valid, if_lin.out_idx, if_lin.out_re, if_rev.out_re, fr_re[0]);
        end
        drain();
    endtask

    task automatic test_midreset();
        rand_frame();
        out_ready = 1'b1; load = 1'b1;
        cycle();
        load = 1'b0;
        wait_remaining(9);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({if_lin.out_valid, if_rev.out_valid, if_lin.load_dropped} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_abort valid=%b rev_valid=%b drop=%b expected 000", if_lin.out_valid, if_rev.out_valid, if_lin.load_dropped);
        end
        cycle();
        rand_frame();
        load = 1'b1;
        cycle();
        load = 1'b0;
        checks++;
        if ({if_lin.out_idx, if_lin.out_re, if_lin.out_im} !== {4'h0, fr_re[0], fr_im[0]}) begin
            errors++;
            $display("FAIL midreset_restart idx=%0d re=%h im=%h expected 0 %h %h", if_lin.out_idx, if_lin.out_re, if_lin.out_im, fr_re[0], fr_im[0]);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 7) == 0);
            if (load) rand_frame();
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_linear();
        test_backpressure();
        test_reorder();
        test_collision();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
